regfile_cc: RTL and testbench
=============================

# regfile_cc

Architectural state consumer for the LC-3b datapath's ALU result. It holds the eight 16-bit general-purpose registers R0–R7, whose two read ports drive the ALU operands. It captures results from the shared bus into a destination register, derives and latches the N/Z/P condition codes, and latches the branch-enable bit (BEN) used by the microsequencer.

## Interface
- WIDTH, 16, data width of registers and bus.
- NREGS, 8, number of registers; address width is clog2(NREGS) = 3.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- BUS  input  WIDTH  shared datapath bus; carries ALU_out when the ALU is gated.
- LD_REG  input  1  write BUS into register DR this edge.
- DR  input  3  destination register index.
- SR1  input  3  read port 1 index, feeding ALU A.
- SR2  input  3  read port 2 index, feeding ALU B.
- LD_CC  input  1  load N/Z/P from BUS this edge.
- LD_BEN  input  1  load BEN this edge.
- IR_NZP  input  3  IR[11:9] branch condition mask, {n,z,p}.
- SR1_out  output  WIDTH  contents of R[SR1], combinational.
- SR2_out  output  WIDTH  contents of R[SR2], combinational.
- N, Z, P  output  1 each  registered condition codes.
- BEN  output  1  registered branch enable.

## Operation
- **Register file:** NREGS x WIDTH flops.
  - If LD_REG=1 at a rising edge, R[DR] <= BUS. Otherwise all registers hold.
  - There is no hardwired-zero register. R7 is an ordinary register; link writes arrive via DR=7.
- **Read ports:** purely combinational muxes, SR1_out = R[SR1] and SR2_out = R[SR2]. There is no write bypass.
- **Condition codes:** on LD_CC=1, BUS is treated as two's-complement WIDTH bits.
  - N <= BUS[WIDTH-1].
  - Z <= (BUS == 0).
  - P <= ~BUS[WIDTH-1] & (BUS != 0).
  - Exactly one of N/Z/P is 1 at all times, including after reset.
- **BEN:** on LD_BEN=1, BEN <= (IR_NZP[2]&N) | (IR_NZP[1]&Z) | (IR_NZP[0]&P). This uses the currently registered N/Z/P, never the value being loaded in the same edge.
- **Independence:** LD_REG, LD_CC and LD_BEN are independent and may assert together. LD_REG and LD_CC in the same cycle both sample the same BUS value.
- **Reset values:** all registers 0x0000, N=0, Z=1, P=0, BEN=0.
  - Because SR1_out and SR2_out are combinational from cleared registers, both read 0x0000 during reset.
  - Assertion mid-instruction discards any write in flight. No write or load occurs on any edge while reset=1.

## Timing
- **Write latency:** 1 cycle. A value written at edge k appears on SR1_out/SR2_out after edge k (visible in cycle k+1).
- **Read-during-write:** DR == SR1 (or SR2) with LD_REG=1 returns the old value until the edge, then the new value.
- **CC latency:** LD_CC at edge k updates N/Z/P after edge k.
- **Same-edge LD_CC + LD_BEN:** BEN reflects the pre-edge CCs. The new CCs affect BEN only on a later LD_BEN.
- **Reset timing:** outputs go to reset values asynchronously on reset assertion. Deassertion is released synchronously by the system; the first update is the first rising edge with reset=0.
- **Throughput:** one register write plus one CC update plus one BEN update per cycle, no stalls, no handshake. The control store guarantees the input strobes are stable around the edge.

## Test plan
- **Reset:** drive writes to all registers, then assert reset asynchronously mid-cycle.
  - Expect SR1_out=SR2_out=0x0000 for every index, N/Z/P=0/1/0, BEN=0, immediately, without waiting for an edge.
- **Write/read:** write R3<=0x1234 and R5<=0xFFFF on consecutive edges, then set SR1=3, SR2=5 → 0x1234 / 0xFFFF.
  - Same edge, with SR1=3 and LD_REG to R3 of 0xAAAA: SR1_out stays 0x1234 until the edge, then reads 0xAAAA.
- **CC generation:** LD_CC with BUS = 0x8000, 0x0000, 0x7FFF, 0x0001, 0xFFFF in turn.
  - Expected NZP: 100, 010, 001, 001, 100.
  - One-hot holds every cycle.
- **BEN and same-edge ordering:** CC=Z, IR_NZP=3'b010, LD_BEN → BEN=1.
  - Then apply LD_CC with BUS=0x0005 and LD_BEN on the same edge with IR_NZP=3'b010 → BEN=1 (old Z), P=1 afterward.
  - Next LD_BEN → BEN=0.
- **Simultaneous LD_REG + LD_CC:** BUS=0xFF80, DR=7 → R7=0xFF80, NZP=100 after one edge.
  - Registers other than R7 are unchanged.
- **Hold:** all strobes low for 10 cycles while BUS toggles randomly → no register, CC or BEN change.

Source files
------------

// File: rtl/regfile_cc.sv
// LC-3b general-purpose register file with N/Z/P condition codes and branch-enable latch.
// Two combinational read ports feed the ALU; writes, CC loads and BEN loads are independent per edge.
module regfile_cc #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] BUS,
    input  logic             LD_REG,
    input  logic [AW-1:0]    DR,
    input  logic [AW-1:0]    SR1,
    input  logic [AW-1:0]    SR2,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic [2:0]       IR_NZP,
    output logic [WIDTH-1:0] SR1_out,
    output logic [WIDTH-1:0] SR2_out,
    output logic             N,
    output logic             Z,
    output logic             P,
    output logic             BEN
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [2:0]       nzp_q;
    logic [2:0]       nzp_d;
    logic             ben_q;
    logic             ben_d;

    // One-hot {n,z,p} classification of a two's-complement value.
    function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
        logic is_zero;
        is_zero = (v == {WIDTH{1'b0}});
        cc_of   = {v[WIDTH-1], is_zero, ~v[WIDTH-1] & ~is_zero};
    endfunction

    // Next-state for registers, condition codes and BEN; BEN always sees the pre-edge CCs.
    always_comb begin
        regs_d = regs_q;
        nzp_d  = nzp_q;
        ben_d  = ben_q;
        if (LD_REG) begin
            regs_d[DR] = BUS;
        end else begin
            regs_d = regs_q;
        end
        if (LD_CC) begin
            nzp_d = cc_of(BUS);
        end else begin
            nzp_d = nzp_q;
        end
        if (LD_BEN) begin
            ben_d = |(IR_NZP & nzp_q);
        end else begin
            ben_d = ben_q;
        end
    end

    // State registers; reset leaves CCs at Z so exactly one code is always set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            nzp_q <= nzp_d;
            ben_q <= ben_d;
        end
    end

    assign SR1_out = regs_q[SR1];
    assign SR2_out = regs_q[SR2];
    assign N       = nzp_q[2];
    assign Z       = nzp_q[1];
    assign P       = nzp_q[0];
    assign BEN     = ben_q;

endmodule

// File: tb/tb_regfile_cc.sv
// Self-checking bench for regfile_cc: directed vector table, hand-written corner sequences,
// and randomized traffic compared against an array-based reference model.
module tb_regfile_cc;

    logic        clk;
    logic        reset;
    logic [15:0] BUS;
    logic        LD_REG;
    logic [2:0]  DR;
    logic [2:0]  SR1;
    logic [2:0]  SR2;
    logic        LD_CC;
    logic        LD_BEN;
    logic [2:0]  IR_NZP;
    logic [15:0] SR1_out;
    logic [15:0] SR2_out;
    logic        N;
    logic        Z;
    logic        P;
    logic        BEN;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_regs [8];
    logic        m_n, m_z, m_p, m_ben;

    typedef struct {
        logic [15:0] bus;
        logic        ld_reg;
        logic [2:0]  dr;
        logic        ld_cc;
        logic        ld_ben;
        logic [2:0]  ir;
        logic [2:0]  exp_nzp;
        logic        exp_ben;
    } vec_t;

    vec_t tbl [10];

    regfile_cc dut (
        .clk    (clk),
        .reset  (reset),
        .BUS    (BUS),
        .LD_REG (LD_REG),
        .DR     (DR),
        .SR1    (SR1),
        .SR2    (SR2),
        .LD_CC  (LD_CC),
        .LD_BEN (LD_BEN),
        .IR_NZP (IR_NZP),
        .SR1_out(SR1_out),
        .SR2_out(SR2_out),
        .N      (N),
        .Z      (Z),
        .P      (P),
        .BEN    (BEN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_n = 1'b0; m_z = 1'b1; m_p = 1'b0; m_ben = 1'b0;
    endtask

    // Apply the architectural rules for one rising edge using the current inputs.
    task automatic model_edge();
        logic nb;
        nb = m_ben;
        if (LD_BEN) nb = (IR_NZP[2] && m_n) || (IR_NZP[1] && m_z) || (IR_NZP[0] && m_p);
        if (LD_CC) begin
            m_n = ($signed(BUS) < 0);
            m_z = ($signed(BUS) == 0);
            m_p = ($signed(BUS) > 0);
        end
        if (LD_REG) m_regs[DR] = BUS;
        m_ben = nb;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes_off();
        LD_REG = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0;
    endtask

    task automatic check_cc(input string tag);
        chk({tag, "_nzp"}, {13'd0, N, Z, P}, {13'd0, m_n, m_z, m_p});
        chk({tag, "_onehot"}, {15'd0, (N + Z + P) == 2'd1}, 16'd1);
        chk({tag, "_ben"}, {15'd0, BEN}, {15'd0, m_ben});
    endtask

    task automatic full_check(input string tag);
        for (int i = 0; i < 8; i++) begin
            SR1 = 3'(i);
            SR2 = 3'(7 - i);
            #1;
            chk({tag, "_sr1"}, SR1_out, m_regs[i]);
            chk({tag, "_sr2"}, SR2_out, m_regs[7 - i]);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 8; i++) begin
            SR1 = 3'(i);
            SR2 = 3'(7 - i);
            #0.1;
            chk({tag, "_sr1"}, SR1_out, 16'h0000);
            chk({tag, "_sr2"}, SR2_out, 16'h0000);
        end
        chk({tag, "_nzp"}, {13'd0, N, Z, P}, 16'h0002);
        chk({tag, "_ben"}, {15'd0, BEN}, 16'h0000);
    endtask

    initial begin
        logic [15:0] snap_regs [8];
        logic [3:0]  snap_cc;

        BUS = 16'h0; DR = 3'd0; SR1 = 3'd0; SR2 = 3'd0; IR_NZP = 3'b000;
        strobes_off();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        // Write / read and read-during-write
        LD_REG = 1'b1; DR = 3'd3; BUS = 16'h1234;
        step();
        DR = 3'd5; BUS = 16'hFFFF;
        step();
        LD_REG = 1'b0; SR1 = 3'd3; SR2 = 3'd5;
        #1;
        chk("wr_r3", SR1_out, 16'h1234);
        chk("wr_r5", SR2_out, 16'hFFFF);
        LD_REG = 1'b1; DR = 3'd3; BUS = 16'hAAAA;
        #1;
        chk("rdw_old", SR1_out, 16'h1234);
        step();
        chk("rdw_new", SR1_out, 16'hAAAA);
        strobes_off();

        // Directed table: CC sequence, BEN ordering, simultaneous LD_REG + LD_CC
        tbl[0] = '{16'h8000, 1'b0, 3'd0, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0};
        tbl[1] = '{16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0};
        tbl[2] = '{16'h7FFF, 1'b0, 3'd0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0};
        tbl[3] = '{16'h0001, 1'b0, 3'd0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0};
        tbl[4] = '{16'hFFFF, 1'b0, 3'd0, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0};
        tbl[5] = '{16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0};
        tbl[6] = '{16'h1111, 1'b0, 3'd0, 1'b0, 1'b1, 3'b010, 3'b010, 1'b1};
        tbl[7] = '{16'h0005, 1'b0, 3'd0, 1'b1, 1'b1, 3'b010, 3'b001, 1'b1};
        tbl[8] = '{16'h0000, 1'b0, 3'd0, 1'b0, 1'b1, 3'b010, 3'b001, 1'b0};
        tbl[9] = '{16'hFF80, 1'b1, 3'd7, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0};
        for (int v = 0; v < 10; v++) begin
            BUS = tbl[v].bus; LD_REG = tbl[v].ld_reg; DR = tbl[v].dr;
            LD_CC = tbl[v].ld_cc; LD_BEN = tbl[v].ld_ben; IR_NZP = tbl[v].ir;
            step();
            chk($sformatf("vec%0d_nzp", v), {13'd0, N, Z, P}, {13'd0, tbl[v].exp_nzp});
            chk($sformatf("vec%0d_ben", v), {15'd0, BEN}, {15'd0, tbl[v].exp_ben});
            chk($sformatf("vec%0d_onehot", v), {15'd0, (N + Z + P) == 2'd1}, 16'd1);
        end
        strobes_off();
        SR1 = 3'd7;
        #1;
        chk("r7_link", SR1_out, 16'hFF80);
        full_check("after_tbl");

        // Hold: strobes low, BUS toggling
        for (int i = 0; i < 8; i++) snap_regs[i] = m_regs[i];
        snap_cc = {N, Z, P, BEN};
        for (int c = 0; c < 10; c++) begin
            BUS = 16'($urandom);
            DR = 3'($urandom);
            IR_NZP = 3'($urandom);
            step();
            chk("hold_cc", {12'd0, N, Z, P, BEN}, {12'd0, snap_cc});
        end
        for (int i = 0; i < 8; i++) begin
            SR1 = 3'(i);
            #1;
            chk("hold_reg", SR1_out, snap_regs[i]);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 5))
                0: BUS = 16'h0000;
                1: BUS = 16'h8000;
                2: BUS = 16'h7FFF;
                default: BUS = 16'($urandom);
            endcase
            LD_REG = 1'($urandom); LD_CC = 1'($urandom); LD_BEN = 1'($urandom);
            DR = 3'($urandom); IR_NZP = 3'($urandom);
            SR1 = 3'($urandom); SR2 = 3'($urandom);
            step();
            chk("rnd_sr1", SR1_out, m_regs[SR1]);
            chk("rnd_sr2", SR2_out, m_regs[SR2]);
            check_cc("rnd");
        end
        strobes_off();
        full_check("after_rnd");

        // Mid-cycle asynchronous reset with a write in flight
        for (int i = 0; i < 8; i++) begin
            LD_REG = 1'b1; DR = 3'(i); BUS = 16'h1000 + 16'(i);
            step();
        end
        LD_REG = 1'b0; LD_CC = 1'b1; BUS = 16'h8000;
        step();
        LD_CC = 1'b0; LD_BEN = 1'b1; IR_NZP = 3'b100;
        step();
        chk("pre_rst_ben", {15'd0, BEN}, 16'd1);
        full_check("pre_rst");
        LD_BEN = 1'b1; IR_NZP = 3'b111; LD_REG = 1'b1; DR = 3'd2; BUS = 16'hBEEF; LD_CC = 1'b1;
        #3 reset = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        @(posedge clk);
        #1;
        check_reset_vals("rst_edge");
        strobes_off();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step();
        full_check("post_rst");
        check_cc("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
